cellular_automaton_gen: RTL and testbench
=========================================

# cellular_automaton_gen

Parametrised, programmable one-dimensional cellular-automaton hypervector generator. It holds a `DIMENSION`-cell state vector and advances it by one generation per accepted output under any 8-bit elementary (Wolfram) rule. Boundary mode, seed source and warm-up length are selectable, and the output has a valid/ready handshake. It sits in the item-memory path, producing pseudo-random item hypervectors for the spatial/temporal encoders. It supersedes the fixed-rule, free-running CA generator.

## Interface
- `DIMENSION`, default `HV_DIMENSION`: number of cells; also the output width.
- `SEED`, default `{DIMENSION/2{1'b0}}, 1'b1, {DIMENSION-DIMENSION/2-1{1'b0}}`: built-in seed vector.
- `RULE_DEFAULT`, default 8'd90: rule in force after reset.
- `WARMUP_WIDTH`, default 8: width of the warm-up count.
- `Clk_CI`  in  1  clock; all logic is rising-edge.
- `Reset_RBI`  in  1  asynchronous, active-low reset.
- `Enable_SI`  in  1  advance enable; gates generation steps only.
- `Clear_SI`  in  1  restart: load seed, latch configuration.
- `SeedSel_SI`  in  1  1 = load `Seed_DI`, 0 = load `SEED`; sampled on Clear.
- `Seed_DI`  in  DIMENSION  external seed, index 0 = leftmost cell.
- `Rule_DI`  in  8  elementary rule; sampled on Clear.
- `Boundary_SI`  in  1  0 = periodic ring, 1 = null (zero) edges; sampled on Clear.
- `Warmup_DI`  in  WARMUP_WIDTH  number of discarded generations after Clear.
- `Ready_SI`  in  1  downstream ready.
- `Valid_SO`  out  1  `CellValueOut_DO` holds a usable generation.
- `CellValueOut_DO`  out  DIMENSION  current generation; bit vector `[0:DIMENSION-1]`.
- `StepCount_DO`  out  16  generations computed since the last Clear, saturating at 16'hFFFF.

## Operation
- Reset (asynchronous, `Reset_RBI` = 0) sets:
  - state = `SEED`, rule = `RULE_DEFAULT`, boundary = periodic;
  - warm-up counter = 0, `StepCount_DO` = 0, `Valid_SO` = 0;
  - FSM = IDLE.
- The FSM has three states: IDLE, WARMUP and RUN.
  - IDLE: state frozen and `Valid_SO` = 0. Only Clear leaves IDLE.
  - Clear (any state, independent of `Enable_SI`, highest priority over any step or handshake in the same cycle) does the following:
    - state ← `Seed_DI` or `SEED`;
    - latch rule, boundary and warm-up counter ← `Warmup_DI`;
    - `StepCount_DO` ← 0;
    - next state = WARMUP if `Warmup_DI` ≠ 0, else RUN.
  - WARMUP: each cycle with `Enable_SI` = 1 computes one generation, decrements the counter and increments `StepCount_DO`. When the counter reaches 1 and steps, the next state is RUN. `Valid_SO` = 0 throughout.
  - RUN: `Valid_SO` = 1. A handshake (`Valid_SO` & `Ready_SI` & `Enable_SI`) computes one generation at that edge and increments `StepCount_DO`. With no handshake, the state and output hold exactly.
- Generation rule: new[i] = rule[{L,C,R}], where L = cell[i−1], C = cell[i], R = cell[i+1].
  - Periodic: cell[−1] = cell[D−1] and cell[D] = cell[0].
  - Null: out-of-range neighbours read as 0.
- `Enable_SI` = 0 freezes the state, counters and FSM. `Valid_SO` keeps its value, so downstream sees stable data. A handshake with `Enable_SI` = 0 is not accepted.
- `CellValueOut_DO` is the state register itself (registered output, no combinational path from inputs).
- `StepCount_DO` saturates and never wraps.
- A configuration change without Clear has no effect.

## Timing
- Clear sampled at edge k: after edge k the output equals the seed.
  - If `Warmup_DI` = 0, `Valid_SO` = 1 after edge k, and the seed is generation 0.
  - If `Warmup_DI` = W, `Valid_SO` rises after edge k+W (given continuous enable), the output is generation W and `StepCount_DO` = W.
- Throughput: one generation per cycle with `Ready_SI` held high.
- Handshake latency: the data accepted at edge n is replaced by the next generation after edge n.
- Reset deassertion: IDLE on the first edge; no output change until Clear.
- Reset asserted mid-RUN or mid-WARMUP: all outputs go to reset values immediately (asynchronously).

## Test plan
- D=8, rule 90, periodic, seed 00010000, W=0, Ready=1 → outputs 00010000, 00101000, 01000100, 10101010 on successive cycles; `StepCount_DO` = 0, 1, 2, 3.
- D=8, rule 90, seed 10000000 → periodic next = 01000001; null next = 01000000.
- W=3, rule 30, D=8, seed 00010000 → `Valid_SO` = 0 for 3 cycles, then output = 11011110 (generation 3) with `StepCount_DO` = 3.
- In RUN, drop `Ready_SI` for 5 cycles → output, `Valid_SO` and `StepCount_DO` stable. Repeat with `Enable_SI` = 0 and `Ready_SI` = 1 → same stability.
- Clear and a handshake in the same cycle → seed loaded, `StepCount_DO` = 0, and the rule changes to the newly latched `Rule_DI`.
- Assert `Reset_RBI` between clock edges during RUN → `Valid_SO` = 0, output = `SEED` and `StepCount_DO` = 0 before the next edge. The FSM stays IDLE until Clear.

Source files
------------

// File: rtl/cellular_automaton_gen.sv
// Programmable 1-D elementary cellular-automaton hypervector generator with
// selectable boundary, seed source, warm-up length and a valid/ready output.
module cellular_automaton_gen #(
  parameter int unsigned         HV_DIMENSION = 1024,
  parameter int unsigned         DIMENSION    = HV_DIMENSION,
  parameter logic [0:DIMENSION-1] SEED        =
    {{DIMENSION/2{1'b0}}, 1'b1, {DIMENSION-DIMENSION/2-1{1'b0}}},
  parameter logic [7:0]          RULE_DEFAULT = 8'd90,
  parameter int unsigned         WARMUP_WIDTH = 8
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    Enable_SI,
  input  logic                    Clear_SI,
  input  logic                    SeedSel_SI,
  input  logic [0:DIMENSION-1]    Seed_DI,
  input  logic [7:0]              Rule_DI,
  input  logic                    Boundary_SI,
  input  logic [WARMUP_WIDTH-1:0] Warmup_DI,
  input  logic                    Ready_SI,
  output logic                    Valid_SO,
  output logic [0:DIMENSION-1]    CellValueOut_DO,
  output logic [15:0]             StepCount_DO
);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e                  state_q, state_d;
  logic [0:DIMENSION-1]    cells_q, cells_d;
  logic [7:0]              rule_q, rule_d;
  logic                    boundary_q, boundary_d;
  logic [WARMUP_WIDTH-1:0] warm_q, warm_d;
  logic [15:0]             step_cnt_q, step_cnt_d;

  logic                    step;
  logic [0:DIMENSION+1]    padded;
  logic [0:DIMENSION-1]    next_gen;

  // Neighbourhood view with one edge cell on each side; null edges read as zero.
  always_comb begin
    padded = {boundary_q ? 1'b0 : cells_q[DIMENSION-1],
              cells_q,
              boundary_q ? 1'b0 : cells_q[0]};
    next_gen = '0;
    for (int unsigned i = 0; i < DIMENSION; i++) begin
      next_gen[i] = rule_q[{padded[i], padded[i+1], padded[i+2]}];
    end
  end

  // A generation is computed on every enabled warm-up cycle or accepted handshake.
  always_comb begin
    step = 1'b0;
    if (Enable_SI) begin
      unique case (state_q)
        StWarmup: step = 1'b1;
        StRun:    step = Ready_SI;
        default:  step = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (Clear_SI) begin
      state_d = (Warmup_DI != '0) ? StWarmup : StRun;
    end else if (Enable_SI) begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StWarmup: state_d = (warm_q <= WARMUP_WIDTH'(1)) ? StRun : StWarmup;
        StRun:    state_d = StRun;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    Valid_SO = 1'b0;
    unique case (state_q)
      StRun:   Valid_SO = 1'b1;
      default: Valid_SO = 1'b0;
    endcase
  end

  // Datapath next-state; Clear overrides any step in the same cycle.
  always_comb begin
    cells_d    = cells_q;
    rule_d     = rule_q;
    boundary_d = boundary_q;
    warm_d     = warm_q;
    step_cnt_d = step_cnt_q;
    if (Clear_SI) begin
      cells_d    = SeedSel_SI ? Seed_DI : SEED;
      rule_d     = Rule_DI;
      boundary_d = Boundary_SI;
      warm_d     = Warmup_DI;
      step_cnt_d = '0;
    end else if (step) begin
      cells_d = next_gen;
      if (warm_q != '0) begin
        warm_d = warm_q - WARMUP_WIDTH'(1);
      end
      if (step_cnt_q != 16'hFFFF) begin
        step_cnt_d = step_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      cells_q    <= SEED;
      rule_q     <= RULE_DEFAULT;
      boundary_q <= 1'b0;
      warm_q     <= '0;
      step_cnt_q <= '0;
    end else begin
      cells_q    <= cells_d;
      rule_q     <= rule_d;
      boundary_q <= boundary_d;
      warm_q     <= warm_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign CellValueOut_DO = cells_q;
  assign StepCount_DO    = step_cnt_q;

endmodule

// File: tb/tb_cellular_automaton_gen.sv
// Randomized and directed bench for cellular_automaton_gen against a behavioural
// model of the automaton (modular neighbour indexing, integer counters).
module tb_cellular_automaton_gen;

  localparam int D = 8;
  localparam logic [0:D-1] SEED_V = 8'b00001000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0, clear = 1'b0, seed_sel = 1'b0, boundary = 1'b0, ready = 1'b0;
  logic [0:D-1]   seed = '0;
  logic [7:0]     rule = '0, warmup = '0;
  logic           valid;
  logic [0:D-1]   cells_out;
  logic [15:0]    step_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [0:D-1] m_cells;
  logic [7:0]   m_rule;
  bit           m_null;
  int           m_warm, m_cnt;
  bit           m_started;

  always #5 clk = ~clk;

  cellular_automaton_gen #(
    .DIMENSION   (D),
    .RULE_DEFAULT(8'd90),
    .WARMUP_WIDTH(8)
  ) dut (
    .Clk_CI         (clk),
    .Reset_RBI      (rst_n),
    .Enable_SI      (enable),
    .Clear_SI       (clear),
    .SeedSel_SI     (seed_sel),
    .Seed_DI        (seed),
    .Rule_DI        (rule),
    .Boundary_SI    (boundary),
    .Warmup_DI      (warmup),
    .Ready_SI       (ready),
    .Valid_SO       (valid),
    .CellValueOut_DO(cells_out),
    .StepCount_DO   (step_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:D-1] ca_next(input logic [0:D-1] c, input logic [7:0] r,
                                           input bit nul);
    logic [0:D-1] n;
    int l, rr, idx;
    for (int i = 0; i < D; i++) begin
      l  = (nul && i == 0) ? 0 : int'(c[(i + D - 1) % D]);
      rr = (nul && i == D - 1) ? 0 : int'(c[(i + 1) % D]);
      idx = 4 * l + 2 * int'(c[i]) + rr;
      n[i] = r[idx];
    end
    return n;
  endfunction

  task automatic model_reset();
    m_cells = SEED_V; m_rule = 8'd90; m_null = 0;
    m_warm = 0; m_cnt = 0; m_started = 0;
  endtask

  task automatic model_step();
    if (clear) begin
      m_cells = seed_sel ? seed : SEED_V;
      m_rule = rule; m_null = boundary;
      m_warm = int'(warmup); m_cnt = 0; m_started = 1;
    end else if (m_started && enable && (m_warm > 0 || ready)) begin
      m_cells = ca_next(m_cells, m_rule, m_null);
      if (m_warm > 0) m_warm--;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(m_started && m_warm == 0));
    check({tag, ".cells"}, 32'(cells_out), 32'(m_cells));
    check({tag, ".count"}, 32'(step_cnt), 32'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    model_step();
    compare_model(tag);
  endtask

  task automatic do_clear(input logic [0:D-1] s, input logic [7:0] r, input logic b,
                          input logic [7:0] w, input string tag);
    clear = 1; seed_sel = 1; seed = s; rule = r; boundary = b; warmup = w;
    cycle(tag);
    clear = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.cells", 32'(cells_out), 32'(SEED_V));
    check("rst.count", 32'(step_cnt), 32'd0);
    rst_n = 1;
    enable = 1; ready = 1;
    repeat (3) cycle("idle");

    // Rule 90 periodic from 00010000, no warm-up
    do_clear(8'b00010000, 8'd90, 1'b0, 8'd0, "r90.clr");
    check("r90.g0", 32'(cells_out), 32'h10);
    rule = 8'd30; boundary = 1;  // unlatched config must be ignored
    cycle("r90.s1"); check("r90.g1", 32'(cells_out), 32'h28);
    cycle("r90.s2"); check("r90.g2", 32'(cells_out), 32'h44);
    cycle("r90.s3"); check("r90.g3", 32'(cells_out), 32'hAA);
    check("r90.cnt3", 32'(step_cnt), 32'd3);

    // Boundary modes from 10000000
    do_clear(8'b10000000, 8'd90, 1'b0, 8'd0, "per.clr");
    cycle("per.s1"); check("per.g1", 32'(cells_out), 32'h41);
    do_clear(8'b10000000, 8'd90, 1'b1, 8'd0, "nul.clr");
    cycle("nul.s1"); check("nul.g1", 32'(cells_out), 32'h40);

    // Warm-up of 3 under rule 30, ready low must not matter during warm-up
    ready = 0;
    do_clear(8'b00010000, 8'd30, 1'b0, 8'd3, "wu.clr");
    check("wu.v0", 32'(valid), 32'd0);
    cycle("wu.s1"); check("wu.v1", 32'(valid), 32'd0);
    cycle("wu.s2"); check("wu.v2", 32'(valid), 32'd0);
    cycle("wu.s3");
    check("wu.v3", 32'(valid), 32'd1);
    check("wu.g3", 32'(cells_out), 32'hDE);
    check("wu.cnt", 32'(step_cnt), 32'd3);

    // Stall: ready low, then enable low with ready high
    repeat (5) cycle("stall.rdy");
    check("stall.rdy.g", 32'(cells_out), 32'hDE);
    ready = 1; enable = 0;
    repeat (5) cycle("stall.en");
    check("stall.en.g", 32'(cells_out), 32'hDE);
    check("stall.en.cnt", 32'(step_cnt), 32'd3);
    enable = 1;
    cycle("resume");

    // Clear coincident with a handshake latches the new rule
    do_clear(8'b00010000, 8'd90, 1'b0, 8'd0, "clrhs.clr");
    check("clrhs.g0", 32'(cells_out), 32'h10);
    check("clrhs.cnt", 32'(step_cnt), 32'd0);
    cycle("clrhs.s1"); check("clrhs.g1", 32'(cells_out), 32'h28);

    // Asynchronous reset between edges during RUN
    cycle("pre.rst");
    @(posedge clk);
    model_step();
    #3 rst_n = 0;
    #1;
    check("arst.valid", 32'(valid), 32'd0);
    check("arst.cells", 32'(cells_out), 32'(SEED_V));
    check("arst.count", 32'(step_cnt), 32'd0);
    model_reset();
    #2 rst_n = 1;
    repeat (3) cycle("post.rst");
    check("post.rst.cells", 32'(cells_out), 32'(SEED_V));

    // Step counter saturation
    do_clear(8'b01101001, 8'd110, 1'b0, 8'd0, "sat.clr");
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      #1;
      model_step();
    end
    check("sat.count", 32'(step_cnt), 32'hFFFF);
    compare_model("sat");

    // Randomized traffic
    do_clear(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
             "rnd.clr0");
    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(0, 19) == 0);
      seed_sel = 1'($urandom_range(0, 1));
      seed     = 8'($urandom);
      rule     = 8'($urandom);
      boundary = 1'($urandom_range(0, 1));
      warmup   = 8'($urandom_range(0, 4));
      enable   = ($urandom_range(0, 9) < 8);
      ready    = ($urandom_range(0, 9) < 7);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
